uart_frame_decoder: RTL and testbench
=====================================

Name: uart_frame_decoder

Overview:
- Sits directly downstream of the UART receiver and consumes its one-cycle rx_byte_ready/rx_data byte stream.
- Hunts for a sync byte, then reads a length byte, 1..MAX_LEN payload bytes and an XOR checksum byte.
- Packs the payload into one parallel word and presents it with a one-cycle frame_valid.
- Malformed, corrupted or stalled frames are dropped and flagged with a one-cycle frame_error and an error code.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 4: maximum payload bytes; output word is 8*MAX_LEN bits wide.
- TIMEOUT_CLKS, 1000: maximum idle clocks between bytes inside a frame.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- rx_byte_ready, input, 1: one-cycle strobe meaning rx_data holds a new byte.
- rx_data, input, 8: received byte, sampled only when rx_byte_ready=1.
- frame_data, output, 8*MAX_LEN: payload; byte i occupies bits [8i+7:8i]; unused upper bytes are 0.
- frame_len, output, 8: payload length of the last good frame.
- frame_valid, output, 1: one-cycle pulse when a good frame completes.
- frame_error, output, 1: one-cycle pulse when a frame is dropped.
- error_code, output, 2: reason for the drop; 01 bad length, 10 checksum mismatch, 11 timeout. Held until the next frame_error.

Behaviour:
- Reset (async, active-high): state goes to S_HUNT; frame_data, frame_len, error_code and all internal registers clear to 0. frame_valid and frame_error are 0 immediately.
- A reset mid-frame discards the partial frame silently, with no error pulse.
- All outputs are registered.
- State machine, advancing only on rx_byte_ready unless noted:
  - S_HUNT: a byte equal to SYNC_BYTE moves to S_LEN. Any other byte is discarded.
  - S_LEN: a byte L with 1<=L<=MAX_LEN is stored as the length and sets chk=L. Move to S_PAYLOAD, byte index 0.
  - S_LEN with L=0 or L>MAX_LEN: frame_error with code 01, return to S_HUNT. That byte is not re-examined as a sync byte.
  - S_PAYLOAD: write the byte into shadow slot [index]; chk ^= byte; index++. When index reaches L, move to S_CHECK.
  - S_CHECK: if byte == chk, copy the shadow word to frame_data, upper unused slots zeroed. Load frame_len=L, pulse frame_valid, return to S_HUNT.
  - S_CHECK with byte != chk: frame_error with code 10. frame_data and frame_len keep their previous values. Return to S_HUNT.
- Latency: frame_valid or frame_error is asserted on the clock edge after the rx_byte_ready cycle that carries the deciding byte.
- Timeout:
  - The counter clears on every rx_byte_ready and in S_HUNT, and increments every clock in the other states.
  - When it reaches TIMEOUT_CLKS-1 with no byte that cycle: frame_error with code 11, return to S_HUNT.
  - If a byte arrives in the same cycle as expiry, the byte wins and there is no timeout.
- The shadow word is cleared on entry to S_LEN, so stale bytes never leak into a shorter frame.
- A valid SYNC_BYTE appearing inside the payload or checksum is treated as data; there is no resynchronisation.
- frame_valid and frame_error are mutually exclusive; at most one pulse per frame.
- Widths:
  - Byte index is clog2(MAX_LEN+1) bits.
  - Timeout counter is clog2(TIMEOUT_CLKS) bits; it saturates and never wraps.

Decomposition:
- Shared package holds the state encoding (S_HUNT=0, S_LEN=1, S_PAYLOAD=2, S_CHECK=3) and the error-code constants (ERR_LEN=2'b01, ERR_CHK=2'b10, ERR_TMO=2'b11).
- One natural sub-module: frame_timeout_counter, with clear, enable and an expired output, parameterised by TIMEOUT_CLKS.
- Everything else lives in one module.

Test Plan:
- Good frame: A5,02,11,22,31 -> frame_valid=1 for one cycle after the 31 strobe; frame_len=2; frame_data=32'h0000_2211; frame_error stays 0.
- Bad checksum: A5,03,01,02,03,04 (correct value 03) -> frame_error pulse, error_code=10; frame_data and frame_len keep their prior values; no frame_valid.
- Bad length then recovery: A5,05 -> error_code=01. Then A5,01,7E,7F -> frame_valid, frame_data=32'h0000_007E, frame_len=1.
- Timeout: A5,02,11 followed by silence -> frame_error with code 11 exactly TIMEOUT_CLKS clocks after the 11 strobe. Repeat with a byte landing on the expiry cycle -> no timeout.
- Hunting: 00,FF,5A,A5,01,AA,AB -> exactly one frame_valid, frame_data=32'h0000_00AA; no error pulses.
- Reset mid-payload: assert reset after A5,04,01 -> outputs are 0 asynchronously and no error pulse. After release, A5,01,55,54 -> frame_valid, frame_data=32'h0000_0055.

Source files
------------

// File: rtl/uart_frame_decoder_pkg.sv
// Shared definitions for the UART frame decoder: FSM state encoding,
// drop-reason codes and a small width helper.
package uart_frame_decoder_pkg;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte idle timer for the frame decoder.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : return the count to zero (has priority over enable_i)
//   enable_i     : count one clock; saturates at TIMEOUT_CLKS-1
//   expired_o    : registered, high while the count sits at TIMEOUT_CLKS-1
module frame_timeout_counter
  import uart_frame_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q;

  // Next count: clear wins, otherwise count up and hold at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // expired is derived from the next count so it lines up with cnt_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      expired_q <= (LAST == '0);
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == LAST);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/uart_frame_decoder.sv
// Frame decoder placed after a UART receiver. Hunts for SYNC_BYTE, reads a
// length byte, 1..MAX_LEN payload bytes and an XOR checksum, then publishes
// the payload as one word with a one-cycle frame_valid. Bad frames raise a
// one-cycle frame_error with a held error_code.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   rx_byte_ready  : one-cycle strobe, rx_data carries a new byte
//   rx_data        : received byte
//   frame_data     : payload of the last good frame, byte i at [8i+7:8i]
//   frame_len      : payload length of the last good frame
//   frame_valid    : pulse on a good frame
//   frame_error    : pulse on a dropped frame
//   error_code     : reason of the last drop (held)
module uart_frame_decoder
  import uart_frame_decoder_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN      = 4,
  parameter int unsigned TIMEOUT_CLKS = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_byte_ready,
  input  logic [7:0]           rx_data,
  output logic [8*MAX_LEN-1:0] frame_data,
  output logic [7:0]           frame_len,
  output logic                 frame_valid,
  output logic                 frame_error,
  output logic [1:0]           error_code
);

  localparam int unsigned DATA_W  = 8 * MAX_LEN;
  localparam int unsigned IDX_W   = cnt_width(MAX_LEN + 1);
  localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN);

  state_e              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          chk_q, chk_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [7:0]          flen_q, flen_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic [1:0]          code_q, code_d;

  logic                tmo_expired;
  logic                tmo_fire;
  logic [IDX_W-1:0]    idx_next;

  // Idle timer: held clear while hunting and on every byte.
  frame_timeout_counter #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .clk_i     (clock),
    .rst_i     (reset),
    .clear_i   (rx_byte_ready || (state_q == S_HUNT)),
    .enable_i  (state_q != S_HUNT),
    .expired_o (tmo_expired)
  );

  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign tmo_fire = (state_q != S_HUNT) && tmo_expired && !rx_byte_ready;
  assign idx_next = idx_q + IDX_W'(1);

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    flen_d   = flen_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    code_d   = code_q;

    if (tmo_fire) begin
      error_d = 1'b1;
      code_d  = ERR_TMO;
      state_d = S_HUNT;
    end else if (rx_byte_ready) begin
      case (state_q)
        S_HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            // Fresh shadow so a short frame never carries stale upper bytes.
            shadow_d = '0;
            state_d  = S_LEN;
          end
        end
        S_LEN: begin
          if ((rx_data != 8'd0) && (rx_data <= LEN_MAX)) begin
            len_d   = rx_data;
            chk_d   = rx_data;
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end else begin
            error_d = 1'b1;
            code_d  = ERR_LEN;
            state_d = S_HUNT;
          end
        end
        S_PAYLOAD: begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
              shadow_d[8*i +: 8] = rx_data;
            end
          end
          chk_d = chk_q ^ rx_data;
          idx_d = idx_next;
          if (8'(idx_next) == len_q) begin
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (rx_data == chk_q) begin
            data_d  = shadow_q;
            flen_d  = len_q;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
            code_d  = ERR_CHK;
          end
          state_d = S_HUNT;
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_HUNT;
      len_q    <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      flen_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      flen_q   <= flen_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      code_q   <= code_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_len   = flen_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign error_code  = code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: table of byte sequences with a
// scoreboard of expected pulses, plus timeout and reset sequences.
module tb_uart_frame_decoder;

  localparam int unsigned MAX_LEN      = 4;
  localparam int unsigned TIMEOUT_CLKS = 1000;
  localparam int unsigned DW           = 8 * MAX_LEN;
  localparam int          K_VALID      = 1;
  localparam int          K_ERROR      = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rx_byte_ready = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [DW-1:0] frame_data;
  logic [7:0]    frame_len;
  logic          frame_valid;
  logic          frame_error;
  logic [1:0]    error_code;

  uart_frame_decoder #(
    .SYNC_BYTE    (8'hA5),
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_byte_ready (rx_byte_ready),
    .rx_data       (rx_data),
    .frame_data    (frame_data),
    .frame_len     (frame_len),
    .frame_valid   (frame_valid),
    .frame_error   (frame_error),
    .error_code    (error_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] seq;   // first byte in the most significant used byte
    int          n;
    int          dec;   // index of the deciding byte, -1 for none
    int          kind;
    logic [1:0]  code;
    logic [31:0] data;
    logic [7:0]  len;
  } vec_t;

  typedef struct {
    int          kind;
    logic [1:0]  code;
    logic [31:0] data;
    logic [7:0]  len;
    int          due;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[13];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] last_data = '0;
  logic [7:0]  last_len = '0;
  logic [1:0]  last_code = '0;

  function automatic vec_t mkv(input logic [63:0] seq, input int n, input int dec,
                               input int kind, input logic [1:0] code,
                               input logic [31:0] data, input logic [7:0] len);
    vec_t v;
    v.seq = seq; v.n = n; v.dec = dec; v.kind = kind;
    v.code = code; v.data = data; v.len = len;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update plus scoreboard push; delay counts clocks until the pulse.
  task automatic push_exp(input int kind, input logic [1:0] code,
                          input logic [31:0] data, input logic [7:0] len, input int delay);
    exp_t e;
    if (kind == K_VALID) begin
      last_data = data;
      last_len  = len;
    end else begin
      last_code = code;
    end
    e.kind = kind; e.code = last_code; e.data = last_data; e.len = last_len;
    e.due  = cyc + delay;
    sb.push_back(e);
  endtask

  // Advance one clock and check any pulse against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    if (frame_valid || frame_error) begin
      check("pulse_exclusive", 64'(frame_valid & frame_error), 64'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b code=%0b, expected no pulse (cycle %0d)",
                 frame_valid, frame_error, error_code, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 64'({frame_error, frame_valid}), 64'(e.kind));
        check("pulse_cycle", 64'(cyc), 64'(e.due));
        check("error_code", 64'(error_code), 64'(e.code));
        check("frame_data", 64'(frame_data), 64'(e.data));
        check("frame_len", 64'(frame_len), 64'(e.len));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_ready = 1'b1;
    rx_data       = b;
    tick();
    rx_byte_ready = 1'b0;
    rx_data       = 8'h00;
  endtask

  task automatic drain(input int extra);
    repeat (extra) tick();
    check("pending_pulses", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_frame_data"}, 64'(frame_data), 64'd0);
    check({tag, "_frame_len"}, 64'(frame_len), 64'd0);
    check({tag, "_error_code"}, 64'(error_code), 64'd0);
    check({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
    check({tag, "_frame_error"}, 64'(frame_error), 64'd0);
  endtask

  initial begin
    tbl[0]  = mkv(64'hA5_02_11_22_31,       5, 4, K_VALID, 2'b00, 32'h0000_2211, 8'd2);
    tbl[1]  = mkv(64'hA5_03_01_02_03_04,    6, 5, K_ERROR, 2'b10, 32'h0, 8'd0);
    tbl[2]  = mkv(64'hA5_05,                2, 1, K_ERROR, 2'b01, 32'h0, 8'd0);
    tbl[3]  = mkv(64'hA5_01_7E_7F,          4, 3, K_VALID, 2'b00, 32'h0000_007E, 8'd1);
    tbl[4]  = mkv(64'h00_FF_5A_A5_01_AA_AB, 7, 6, K_VALID, 2'b00, 32'h0000_00AA, 8'd1);
    tbl[5]  = mkv(64'hA5_00,                2, 1, K_ERROR, 2'b01, 32'h0, 8'd0);
    tbl[6]  = mkv(64'hA5_04_A5_11_22_33_A1, 7, 6, K_VALID, 2'b00, 32'h3322_11A5, 8'd4);
    tbl[7]  = mkv(64'hA5_02_5A_01_00,       5, 4, K_ERROR, 2'b10, 32'h0, 8'd0);
    tbl[8]  = mkv(64'hA5_01_C3_C2,          4, 3, K_VALID, 2'b00, 32'h0000_00C3, 8'd1);
    tbl[9]  = mkv(64'hA5_FF,                2, 1, K_ERROR, 2'b01, 32'h0, 8'd0);
    tbl[10] = mkv(64'hA5_03_10_20_30_03,    6, 5, K_VALID, 2'b00, 32'h0030_2010, 8'd3);
    tbl[11] = mkv(64'hA5_A5_01_01_00,       5, 1, K_ERROR, 2'b01, 32'h0, 8'd0);
    tbl[12] = mkv(64'hA5_01_00_01,          4, 3, K_VALID, 2'b00, 32'h0000_0000, 8'd1);

    // Reset state
    #1 reset = 1'b1;
    #1 check_zero_outputs("reset");
    repeat (2) tick();
    reset = 1'b0;
    drain(2);

    // Table-driven frames
    foreach (tbl[v]) begin
      for (int i = 0; i < tbl[v].n; i++) begin
        if (i == tbl[v].dec) begin
          push_exp(tbl[v].kind, tbl[v].code, tbl[v].data, tbl[v].len, 1);
        end
        send_byte(tbl[v].seq[8*(tbl[v].n-1-i) +: 8]);
      end
      drain(3);
    end

    // Timeout: error exactly TIMEOUT_CLKS clocks after the last byte
    send_byte(8'hA5);
    send_byte(8'h02);
    push_exp(K_ERROR, 2'b11, 32'h0, 8'd0, 1 + TIMEOUT_CLKS);
    send_byte(8'h11);
    drain(TIMEOUT_CLKS + 5);

    // Byte lands on the expiry cycle: no timeout, frame completes
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (TIMEOUT_CLKS - 1) tick();
    send_byte(8'h22);
    push_exp(K_VALID, 2'b00, 32'h0000_2211, 8'd2, 1);
    send_byte(8'h31);
    drain(3);

    // Reset mid-payload: asynchronous clear, no pulse
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    #2 reset = 1'b1;
    #1 check_zero_outputs("midreset");
    repeat (3) tick();
    reset = 1'b0;
    last_data = '0;
    last_len  = '0;
    last_code = '0;
    drain(2);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h55);
    push_exp(K_VALID, 2'b00, 32'h0000_0055, 8'd1, 1);
    send_byte(8'h54);
    drain(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
